// File: rtl/param_stream_fifo.sv
// rtl/param_stream_fifo.sv - parameterised first-word-fall-through stream FIFO with preload and flush
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous soft clear back to the preload state
//   din_*           write stream (valid/ready/data/eot); din_eot[1] may act as flush
//   dout_*          read stream (valid/ready/data/eot), head entry shown combinationally
//   level           current occupancy, 0..DEPTH
//   almost_full     level >= AF_LEVEL
//   almost_empty    level <= AE_LEVEL

module param_stream_fifo #(
  parameter int W_DATA       = 8,
  parameter int DEPTH        = 32,
  parameter int PRELOAD      = 4,
  parameter int AF_LEVEL     = DEPTH - 4,
  parameter int AE_LEVEL     = 4,
  parameter bit FLUSH_ON_EOT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [W_DATA-1:0]          din_data,
  input  logic [1:0]                 din_eot,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [W_DATA-1:0]          dout_data,
  output logic [1:0]                 dout_eot,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int EW = W_DATA + 2;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRE  = LW'(PRELOAD);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_PRE  = PW'(PRELOAD % DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("param_stream_fifo: DEPTH must be >= 2");
  end
  if (PRELOAD < 0 || PRELOAD > DEPTH) begin : g_bad_preload
    $error("param_stream_fifo: PRELOAD must be in 0..DEPTH");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_stream_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_stream_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (W_DATA < 1) begin : g_bad_width
    $error("param_stream_fifo: W_DATA must be >= 1");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          flush_now;
  logic          wr_en;
  logic          rd_en;

  assign dout_valid   = (level != '0);
  // A full FIFO still accepts a beat when the head is leaving in the same cycle.
  assign din_ready    = (level != LVL_FULL) | dout_ready;
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  // An end-of-transfer beat with eot[1] set is consumed as a flush, never stored.
  assign flush_now = flush | (FLUSH_ON_EOT & din_valid & din_eot[1]);
  assign wr_en     = din_valid & din_ready & ~flush_now;
  assign rd_en     = dout_valid & dout_ready & ~flush_now;

  // Head entry is driven straight from storage: first-word-fall-through.
  assign {dout_eot, dout_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      // Preload entries are simply the zeroed slots between rd_ptr and wr_ptr.
      rd_ptr <= '0;
      wr_ptr <= PTR_PRE;
      level  <= LVL_PRE;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {din_eot, din_data};
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stream_fifo.sv
// tb/tb_param_stream_fifo.sv - randomized scoreboard bench for param_stream_fifo (two configurations)

module tb_param_stream_fifo;

  localparam int DA  = 32;
  localparam int PA  = 4;
  localparam int AFA = 28;
  localparam int AEA = 4;
  localparam int DB  = 5;
  localparam int PB  = 0;
  localparam int AFB = 1;
  localparam int AEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: default configuration, eot flush enabled
  logic       rst_a, a_flush, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic [7:0] a_din_data, a_dout_data;
  logic [1:0] a_din_eot, a_dout_eot;
  logic [5:0] a_level;
  logic       a_af, a_ae;

  param_stream_fifo #(
    .W_DATA(8), .DEPTH(DA), .PRELOAD(PA), .AF_LEVEL(AFA), .AE_LEVEL(AEA), .FLUSH_ON_EOT(1'b1)
  ) u_a (
    .clk(clk), .rst(rst_a), .flush(a_flush),
    .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data), .din_eot(a_din_eot),
    .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout_data(a_dout_data), .dout_eot(a_dout_eot),
    .level(a_level), .almost_full(a_af), .almost_empty(a_ae)
  );

  // Instance B: small odd depth, no preload, eot passes through
  logic       rst_b, b_flush, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic [7:0] b_din_data, b_dout_data;
  logic [1:0] b_din_eot, b_dout_eot;
  logic [2:0] b_level;
  logic       b_af, b_ae;

  param_stream_fifo #(
    .W_DATA(8), .DEPTH(DB), .PRELOAD(PB), .AF_LEVEL(AFB), .AE_LEVEL(AEB), .FLUSH_ON_EOT(1'b0)
  ) u_b (
    .clk(clk), .rst(rst_b), .flush(b_flush),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data), .din_eot(b_din_eot),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout_data(b_dout_data), .dout_eot(b_dout_eot),
    .level(b_level), .almost_full(b_af), .almost_empty(b_ae)
  );

  // Reference models: an ordered queue of {eot, data} per instance.
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  bit a_init = 1'b0, b_init = 1'b0;
  bit a_exp_rdy, b_exp_rdy, b_wr_acc;
  int a_popped = 0, b_popped = 0;

  // Monitors: check status outputs, then pop/compare on every output transfer.
  always @(negedge clk) begin
    if (a_init) begin
      chk("a_level", 32'(a_level), qa.size());
      chk("a_dout_valid", 32'(a_dout_valid), 32'(qa.size() != 0));
      a_exp_rdy = (qa.size() != DA) || a_dout_ready;
      chk("a_din_ready", 32'(a_din_ready), 32'(a_exp_rdy));
      chk("a_almost_full", 32'(a_af), 32'(qa.size() >= AFA));
      chk("a_almost_empty", 32'(a_ae), 32'(qa.size() <= AEA));
      if (a_dout_valid && a_dout_ready && qa.size() != 0) begin
        chk("a_dout", 32'({a_dout_eot, a_dout_data}), 32'(qa[0]));
        void'(qa.pop_front());
        a_popped++;
      end
    end
    if (b_init) begin
      chk("b_level", 32'(b_level), qb.size());
      chk("b_dout_valid", 32'(b_dout_valid), 32'(qb.size() != 0));
      b_exp_rdy = (qb.size() != DB) || b_dout_ready;
      chk("b_din_ready", 32'(b_din_ready), 32'(b_exp_rdy));
      chk("b_almost_full", 32'(b_af), 32'(qb.size() >= AFB));
      chk("b_almost_empty", 32'(b_ae), 32'(qb.size() <= AEB));
      if (b_dout_valid && b_dout_ready && qb.size() != 0) begin
        chk("b_dout", 32'({b_dout_eot, b_dout_data}), 32'(qb[0]));
        void'(qb.pop_front());
        b_popped++;
      end
    end
  end

  // Model update at the clock edge: reset/flush restore preload, else accept writes.
  always @(posedge clk) begin
    b_wr_acc = 1'b0;
    if (rst_a || (a_init && (a_flush || (a_din_valid && a_din_eot[1])))) begin
      qa.delete();
      for (int i = 0; i < PA; i++) qa.push_back(10'd0);
      a_init = 1'b1;
    end else if (a_init && a_din_valid && a_exp_rdy) begin
      qa.push_back({a_din_eot, a_din_data});
    end
    if (rst_b || (b_init && b_flush)) begin
      qb.delete();
      for (int i = 0; i < PB; i++) qb.push_back(10'd0);
      b_init = 1'b1;
    end else if (b_init && b_din_valid && b_exp_rdy) begin
      qb.push_back({b_din_eot, b_din_data});
      b_wr_acc = 1'b1;
    end
  end

  int next;

  initial begin
    rst_a = 1'b1; a_flush = 1'b0; a_din_valid = 1'b0; a_din_data = '0; a_din_eot = '0; a_dout_ready = 1'b0;
    rst_b = 1'b1; b_flush = 1'b0; b_din_valid = 1'b0; b_din_data = '0; b_din_eot = '0; b_dout_ready = 1'b0;
    tick();
    tick();
    chk("a_reset_level", 32'(a_level), PA);
    chk("a_reset_head", 32'({a_dout_eot, a_dout_data}), 0);
    chk("b_reset_head", 32'({b_dout_eot, b_dout_data}), 0);
    chk("b_reset_valid", 32'(b_dout_valid), 0);

    // Preload drains as exactly PA zero words.
    rst_a = 1'b0; rst_b = 1'b0; a_dout_ready = 1'b1;
    repeat (6) tick();
    chk("a_preload_words", a_popped, PA);
    chk("a_preload_level", 32'(a_level), 0);
    chk("a_preload_valid", 32'(a_dout_valid), 0);

    // Threshold sweep 0..32..0.
    a_dout_ready = 1'b0; a_din_valid = 1'b1;
    for (int i = 0; i < DA + 2; i++) begin
      a_din_data = 8'($urandom);
      a_din_eot  = {1'b0, 1'($urandom)};
      tick();
    end
    chk("a_full_level", 32'(a_level), DA);
    chk("a_full_din_ready", 32'(a_din_ready), 0);
    chk("a_full_af", 32'(a_af), 1);
    a_din_valid = 1'b0; a_dout_ready = 1'b1;
    repeat (DA + 2) tick();
    chk("a_empty_level", 32'(a_level), 0);
    chk("a_empty_ae", 32'(a_ae), 1);

    // eot[1] beat flushes queued words.
    a_dout_ready = 1'b0; a_din_valid = 1'b1; a_din_eot = 2'b00;
    for (int i = 0; i < 3; i++) begin
      a_din_data = 8'h11 + 8'(i);
      tick();
    end
    a_din_data = 8'hEE; a_din_eot = 2'b10;
    tick();
    a_din_valid = 1'b0; a_din_eot = 2'b00;
    chk("a_eot_flush_level", 32'(a_level), PA);
    chk("a_eot_flush_head", 32'({a_dout_eot, a_dout_data}), 0);
    a_dout_ready = 1'b1;
    repeat (6) tick();
    chk("a_eot_drain_level", 32'(a_level), 0);

    // flush beats any transfer; rst beats flush.
    a_dout_ready = 1'b0; a_din_valid = 1'b1; a_din_data = 8'h21;
    tick();
    a_din_data = 8'h22;
    tick();
    a_flush = 1'b1; a_din_data = 8'h55; a_dout_ready = 1'b1;
    tick();
    a_flush = 1'b0; a_dout_ready = 1'b0;
    chk("a_flush_level", 32'(a_level), PA);
    a_din_data = 8'h66;
    tick();
    rst_a = 1'b1; a_flush = 1'b1; a_dout_ready = 1'b1;
    tick();
    rst_a = 1'b0; a_flush = 1'b0; a_din_valid = 1'b0; a_dout_ready = 1'b0;
    chk("a_rst_level", 32'(a_level), PA);
    chk("a_rst_head", 32'({a_dout_eot, a_dout_data}), 0);
    chk("a_rst_din_ready", 32'(a_din_ready), 1);

    // Random traffic on A with occasional flushes and eot flushes.
    for (int i = 0; i < 400; i++) begin
      a_din_valid  = ($urandom_range(0, 3) != 0);
      a_din_data   = 8'($urandom);
      a_din_eot    = {($urandom_range(0, 60) == 0), 1'($urandom)};
      a_dout_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a_flush      = ($urandom_range(0, 150) == 0);
      tick();
    end
    a_din_valid = 1'b0; a_flush = 1'b0; a_din_eot = 2'b00; a_dout_ready = 1'b0;

    // Wrap stream 0..19 through a depth-5 FIFO.
    next = 0; b_popped = 0;
    for (int c = 0; c < 400 && next < 20; c++) begin
      b_din_valid  = ($urandom_range(0, 2) != 0);
      b_din_data   = 8'(next);
      b_dout_ready = 1'($urandom);
      tick();
      if (b_wr_acc) next++;
    end
    b_din_valid = 1'b0; b_dout_ready = 1'b1;
    repeat (8) tick();
    chk("b_wrap_written", next, 20);
    chk("b_wrap_read", b_popped, 20);
    chk("b_wrap_level", 32'(b_level), 0);

    // Fill to full, then read and write together.
    b_dout_ready = 1'b0; b_din_valid = 1'b1;
    for (int i = 0; i < DB; i++) begin
      b_din_data = 8'hA0 + 8'(i);
      tick();
    end
    b_din_data = 8'hAF;
    chk("b_full_din_ready", 32'(b_din_ready), 0);
    chk("b_full_level", 32'(b_level), DB);
    chk("b_full_af", 32'(b_af), 1);
    b_dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_din_data = 8'hB0 + 8'(i);
      tick();
      chk("b_full_rw_level", 32'(b_level), DB);
    end
    b_din_valid = 1'b0;
    repeat (DB + 2) tick();

    // eot[1] is ordinary data with FLUSH_ON_EOT=0.
    b_dout_ready = 1'b0; b_din_valid = 1'b1; b_din_data = 8'h3C; b_din_eot = 2'b10;
    tick();
    b_din_valid = 1'b0; b_din_eot = 2'b00;
    chk("b_eot_level", 32'(b_level), 1);
    chk("b_eot_out", 32'(b_dout_eot), 32'(2'b10));
    chk("b_eot_data", 32'(b_dout_data), 32'h3C);
    b_dout_ready = 1'b1;
    tick();
    chk("b_eot_drained", 32'(b_level), 0);

    // Random traffic on B.
    for (int i = 0; i < 300; i++) begin
      b_din_valid  = ($urandom_range(0, 2) != 0);
      b_din_data   = 8'($urandom);
      b_din_eot    = 2'($urandom);
      b_dout_ready = ($urandom_range(0, 2) != 0);
      b_flush      = ($urandom_range(0, 80) == 0);
      tick();
    end
    b_din_valid = 1'b0; b_flush = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
